// File: rtl/fifo_pkt_reader_if.sv
// Handshake bundle between the upstream FIFO, the packet reader and its consumer.
// The master side is whoever owns the FIFO and the consumer; the reader is the slave.
interface fifo_pkt_reader_if #(
    parameter int DATAWIDTH = 18
);
    logic [DATAWIDTH-1:0] fifo_rd_data;
    logic                 fifo_ne;
    logic                 fifo_re;
    logic [DATAWIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sop;
    logic                 out_eop;

    modport master (
        output fifo_rd_data, fifo_ne, out_ready,
        input  fifo_re, out_data, out_valid, out_sop, out_eop
    );

    modport slave (
        input  fifo_rd_data, fifo_ne, out_ready,
        output fifo_re, out_data, out_valid, out_sop, out_eop
    );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Packet reader: strips length headers from an upstream FIFO stream and delivers
// the payload words with sop/eop framing through a 2-entry skid buffer.
module fifo_pkt_reader #(
    parameter int DATAWIDTH = 18,
    parameter int LENWIDTH  = 10
) (
    input  logic              clk,
    input  logic              reset_l,
    fifo_pkt_reader_if.slave  pkt,
    output logic              hdr_err,
    output logic [15:0]       pkt_cnt
);
    typedef enum logic {HDR, PAY} state_t;
    localparam int EW = DATAWIDTH + 2;

    state_t              state;
    logic [LENWIDTH-1:0] remaining;
    logic                first;
    logic                run;
    logic [1:0]          occ;
    logic [EW-1:0]       skid_p0;
    logic [EW-1:0]       skid_p1;

    logic                pop_in;
    logic                push;
    logic                take;
    logic [EW-1:0]       entry_in;

    // Pop gating looks only at registered occupancy, so out_ready never reaches fifo_re.
    assign pop_in   = run && pkt.fifo_ne && (occ != 2'd2);
    assign push     = pop_in && (state == PAY);
    assign take     = (occ != 2'd0) && pkt.out_ready;
    assign entry_in = {pkt.fifo_rd_data, first, remaining == LENWIDTH'(1)};

    assign pkt.fifo_re   = pop_in;
    assign pkt.out_valid = (occ != 2'd0);
    assign pkt.out_data  = skid_p0[EW-1:2];
    assign pkt.out_sop   = skid_p0[1];
    assign pkt.out_eop   = skid_p0[0];

    // Header/payload parser; run holds pops off for the first cycle after reset release.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state     <= HDR;
            remaining <= '0;
            first     <= 1'b0;
            run       <= 1'b0;
            hdr_err   <= 1'b0;
        end else begin
            run <= 1'b1;
            if (pop_in) begin
                case (state)
                    HDR: begin
                        if (pkt.fifo_rd_data[LENWIDTH-1:0] == '0) begin
                            hdr_err <= 1'b1;
                        end else begin
                            remaining <= pkt.fifo_rd_data[LENWIDTH-1:0];
                            first     <= 1'b1;
                            state     <= PAY;
                        end
                    end
                    PAY: begin
                        first     <= 1'b0;
                        remaining <= remaining - LENWIDTH'(1);
                        if (remaining == LENWIDTH'(1)) begin
                            state <= HDR;
                        end
                    end
                    default: state <= HDR;
                endcase
            end
        end
    end

    // Skid buffer: skid_p0 is always the head entry and directly drives the outputs.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            occ     <= 2'd0;
            skid_p0 <= '0;
            skid_p1 <= '0;
            pkt_cnt <= 16'd0;
        end else begin
            if (take && skid_p0[0]) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            case (occ)
                2'd0: begin
                    if (push) begin
                        skid_p0 <= entry_in;
                        occ     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && take) begin
                        skid_p0 <= entry_in;
                    end else if (push) begin
                        skid_p1 <= entry_in;
                        occ     <= 2'd2;
                    end else if (take) begin
                        occ <= 2'd0;
                    end
                end
                2'd2: begin
                    if (take) begin
                        skid_p0 <= skid_p1;
                        occ     <= 2'd1;
                    end
                end
                default: occ <= 2'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: packet-level scoreboard, table of framing cases,
// back-pressure / reset corner sequences and a long randomized run.
module tb_fifo_pkt_reader;
    localparam int DW = 18;
    localparam int LW = 10;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        hdr_err;
    logic [15:0] pkt_cnt;

    fifo_pkt_reader_if #(.DATAWIDTH(DW)) pkt ();

    fifo_pkt_reader #(.DATAWIDTH(DW), .LENWIDTH(LW)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .pkt     (pkt),
        .hdr_err (hdr_err),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } item_t;

    typedef struct {
        int len;
        int exp_words;
        int exp_re;
        bit exp_err;
        int exp_pkts;
    } vec_t;

    logic [DW-1:0] up_q[$];
    item_t         exp_q[$];

    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    out_cnt = 0;
    int    re_cnt = 0;
    int    first_out = -1;
    int    last_out = -1;
    int    exp_pkts = 0;
    bit    ne_en = 1'b1;
    bit    rdy = 1'b1;
    bit    rnd_mode = 1'b0;
    bit    hold_v = 1'b0;
    item_t hold_i;

    function automatic void check(string name, longint act, longint req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    // Expected output is derived straight from the stream format: L words, sop on the first, eop on the last.
    task automatic add_pkt(int len);
        logic [DW-1:0] h;
        logic [DW-1:0] w;
        item_t         it;
        h = DW'($urandom);
        h[LW-1:0] = LW'(len);
        up_q.push_back(h);
        for (int i = 0; i < len; i++) begin
            w = DW'($urandom);
            up_q.push_back(w);
            it.data = w;
            it.sop  = (i == 0);
            it.eop  = (i == len - 1);
            exp_q.push_back(it);
        end
    endtask

    task automatic tick();
        logic  re_s;
        logic  v_s;
        item_t got;
        item_t want;
        pkt.fifo_ne      = ne_en && (up_q.size() != 0);
        pkt.fifo_rd_data = pkt.fifo_ne ? up_q[0] : DW'($urandom);
        pkt.out_ready    = rdy;
        #1;
        re_s = pkt.fifo_re;
        v_s  = pkt.out_valid;
        got.data = pkt.out_data;
        got.sop  = pkt.out_sop;
        got.eop  = pkt.out_eop;
        if (re_s) check("fifo_re_with_ne", pkt.fifo_ne, 1);
        check("pkt_cnt", pkt_cnt, exp_pkts % 65536);
        if (hold_v) begin
            check("valid_held", v_s, 1);
            if (v_s) check("word_held", got, hold_i);
        end
        if (v_s && rdy) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_output: got %0h, required no output", got);
            end else begin
                want = exp_q.pop_front();
                check("out_word", got, want);
                if (want.eop) exp_pkts++;
            end
            out_cnt++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
        end
        hold_v = v_s && !rdy;
        hold_i = got;
        @(posedge clk);
        if (re_s) begin
            re_cnt++;
            if (up_q.size() != 0) void'(up_q.pop_front());
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while ((up_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            if (rnd_mode) begin
                ne_en = ($urandom_range(0, 3) != 0);
                rdy   = ($urandom_range(0, 3) != 0);
            end
            tick();
            n++;
        end
        check("drain_left", up_q.size() + exp_q.size(), 0);
        ne_en = 1'b1;
        rdy   = 1'b1;
        repeat (3) tick();
    endtask

    task automatic hard_reset();
        reset_l = 1'b0;
        #1;
        up_q.delete();
        exp_q.delete();
        exp_pkts = 0;
        hold_v   = 1'b0;
        @(negedge clk);
        reset_l = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[5];
        int   tbl_pkts;
        int   n;
        tbl[0] = '{len: 3, exp_words: 3, exp_re: 4, exp_err: 1'b0, exp_pkts: 1};
        tbl[1] = '{len: 1, exp_words: 1, exp_re: 2, exp_err: 1'b0, exp_pkts: 2};
        tbl[2] = '{len: 0, exp_words: 0, exp_re: 1, exp_err: 1'b1, exp_pkts: 2};
        tbl[3] = '{len: 2, exp_words: 2, exp_re: 3, exp_err: 1'b1, exp_pkts: 3};
        tbl[4] = '{len: 7, exp_words: 7, exp_re: 8, exp_err: 1'b1, exp_pkts: 4};

        // Reset state with the FIFO claiming data.
        reset_l          = 1'b0;
        pkt.fifo_ne      = 1'b1;
        pkt.fifo_rd_data = DW'(3);
        pkt.out_ready    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_fifo_re", pkt.fifo_re, 0);
        check("rst_out_valid", pkt.out_valid, 0);
        check("rst_out_data", pkt.out_data, 0);
        check("rst_out_sop", pkt.out_sop, 0);
        check("rst_out_eop", pkt.out_eop, 0);
        check("rst_hdr_err", hdr_err, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        reset_l = 1'b1;
        #1;
        check("release_fifo_re", pkt.fifo_re, 0);
        @(negedge clk);

        // Framing table with out_ready and fifo_ne held high.
        tbl_pkts = 0;
        for (int i = 0; i < 5; i++) begin
            out_cnt   = 0;
            re_cnt    = 0;
            first_out = -1;
            last_out  = -1;
            add_pkt(tbl[i].len);
            drain(100);
            check("tbl_words", out_cnt, tbl[i].exp_words);
            check("tbl_pops", re_cnt, tbl[i].exp_re);
            check("tbl_hdr_err", hdr_err, tbl[i].exp_err);
            check("tbl_pkt_cnt", pkt_cnt, tbl[i].exp_pkts);
            if (tbl[i].exp_words > 0)
                check("tbl_back_to_back", last_out - first_out, tbl[i].exp_words - 1);
        end

        // Consumer stalls for 10 cycles with a 5-word packet pending.
        rdy     = 1'b0;
        out_cnt = 0;
        re_cnt  = 0;
        add_pkt(5);
        repeat (10) tick();
        check("stall_pops", re_cnt, 3);
        check("stall_outputs", out_cnt, 0);
        check("stall_fifo_re", pkt.fifo_re, 0);
        check("stall_valid", pkt.out_valid, 1);
        rdy = 1'b1;
        drain(100);
        check("stall_words", out_cnt, 5);

        // Reset after the second payload word of an L=4 packet has been popped.
        re_cnt = 0;
        add_pkt(4);
        n = 0;
        while (re_cnt < 3 && n < 20) begin
            tick();
            n++;
        end
        check("midpkt_pops", re_cnt, 3);
        reset_l = 1'b0;
        #1;
        check("midrst_out_valid", pkt.out_valid, 0);
        check("midrst_out_data", pkt.out_data, 0);
        check("midrst_out_sop", pkt.out_sop, 0);
        check("midrst_out_eop", pkt.out_eop, 0);
        check("midrst_hdr_err", hdr_err, 0);
        check("midrst_pkt_cnt", pkt_cnt, 0);
        check("midrst_fifo_re", pkt.fifo_re, 0);
        up_q.delete();
        exp_q.delete();
        exp_pkts = 0;
        hold_v   = 1'b0;
        @(negedge clk);
        reset_l = 1'b1;
        @(negedge clk);
        out_cnt = 0;
        add_pkt(2);
        drain(100);
        check("postrst_words", out_cnt, 2);
        check("postrst_pkt_cnt", pkt_cnt, 1);

        // Randomized traffic: 1000 packets, random fifo_ne gaps and back-pressure.
        hard_reset();
        add_pkt(1023);
        for (int i = 1; i < 1000; i++) begin
            if ($urandom_range(0, 49) == 0) add_pkt($urandom_range(1, 1023));
            else add_pkt($urandom_range(1, 16));
        end
        rnd_mode = 1'b1;
        drain(80000);
        rnd_mode = 1'b0;
        check("rand_pkt_cnt", pkt_cnt, 1000);
        check("rand_hdr_err", hdr_err, 0);
        check("rand_idle_valid", pkt.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
